// File: rtl/universal_shift_reg.sv
// Universal shift register: single-step ops on en, multi-cycle shift bursts on start.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    input  logic [AMT_W-1:0] amt,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_SHR   = 3'd1,
        OP_SHL   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_ROR   = 3'd4,
        OP_ROL   = 3'd5,
        OP_ASR   = 3'd6,
        OP_CLEAR = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e             state_q;
    op_e                op_q;
    logic               sin_r_q;
    logic               sin_l_q;
    logic [AMT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   q_q;
    logic               sout_r_q;
    logic               sout_l_q;
    logic               busy_q;
    logic               done_q;

    op_e                op_sel;
    logic               sin_r_sel;
    logic               sin_l_sel;
    logic               is_shift_op;
    logic [WIDTH-1:0]   q_d;
    logic               sout_r_d;
    logic               sout_l_d;

    assign q      = q_q;
    assign sout_r = sout_r_q;
    assign sout_l = sout_l_q;
    assign busy   = busy_q;
    assign done   = done_q;

    // Result of one op on the current contents; during a burst the latched op/serial inputs drive it.
    always_comb begin
        op_sel    = (state_q == S_SHIFT) ? op_q    : op_e'(op);
        sin_r_sel = (state_q == S_SHIFT) ? sin_r_q : sin_r;
        sin_l_sel = (state_q == S_SHIFT) ? sin_l_q : sin_l;
        q_d       = q_q;
        sout_r_d  = sout_r_q;
        sout_l_d  = sout_l_q;
        case (op_sel)
            OP_SHR: begin
                q_d      = {sin_r_sel, q_q[WIDTH-1:1]};
                sout_r_d = q_q[0];
            end
            OP_SHL: begin
                q_d      = {q_q[WIDTH-2:0], sin_l_sel};
                sout_l_d = q_q[WIDTH-1];
            end
            OP_LOAD:  q_d = pdata;
            OP_ROR: begin
                q_d      = {q_q[0], q_q[WIDTH-1:1]};
                sout_r_d = q_q[0];
            end
            OP_ROL: begin
                q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                sout_l_d = q_q[WIDTH-1];
            end
            OP_ASR: begin
                q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                sout_r_d = q_q[0];
            end
            OP_CLEAR: q_d = '0;
            default:  q_d = q_q;
        endcase
    end

    // Only shift/rotate ops start a burst; HOLD/LOAD/CLEAR with start act as a single step.
    always_comb begin
        is_shift_op = 1'b0;
        case (op_e'(op))
            OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: is_shift_op = 1'b1;
            default:                               is_shift_op = 1'b0;
        endcase
    end

    // Control FSM plus datapath registers; busy/done are registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_HOLD;
            sin_r_q  <= 1'b0;
            sin_l_q  <= 1'b0;
            cnt_q    <= '0;
            q_q      <= '0;
            sout_r_q <= 1'b0;
            sout_l_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_shift_op) begin
                            if (amt != '0) begin
                                op_q    <= op_e'(op);
                                sin_r_q <= sin_r;
                                sin_l_q <= sin_l;
                                cnt_q   <= amt;
                                busy_q  <= 1'b1;
                                state_q <= S_SHIFT;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end else begin
                            q_q <= q_d;
                        end
                    end else if (en) begin
                        q_q      <= q_d;
                        sout_r_q <= sout_r_d;
                        sout_l_q <= sout_l_d;
                    end
                end
                S_SHIFT: begin
                    q_q      <= q_d;
                    sout_r_q <= sout_r_d;
                    sout_l_q <= sout_l_d;
                    cnt_q    <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Testbench for universal_shift_reg: directed scenarios plus randomized run against a reference model.
module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic [2:0]       op;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pdata;
    logic [AMT_W-1:0] amt;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q, m_sr, m_sl, m_done;
    int m_rem, m_lop, m_lsr, m_lsl;

    universal_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .sin_r(sin_r), .sin_l(sin_l),
        .pdata(pdata), .amt(amt), .start(start), .q(q), .sout_r(sout_r),
        .sout_l(sout_l), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_shift(int o);
        return (o == 1) || (o == 2) || (o == 4) || (o == 5) || (o == 6);
    endfunction

    // Apply one op arithmetically to the model register.
    function automatic void model_apply(int o, int sr, int sl, int pd);
        int top, low;
        top = m_q / 128;
        low = m_q % 2;
        case (o)
            1: begin m_sr = low; m_q = m_q / 2 + sr * 128;   end
            2: begin m_sl = top; m_q = (m_q * 2) % 256 + sl; end
            3: m_q = pd;
            4: begin m_sr = low; m_q = m_q / 2 + low * 128;  end
            5: begin m_sl = top; m_q = (m_q * 2) % 256 + top; end
            6: begin m_sr = low; m_q = m_q / 2 + top * 128;  end
            7: m_q = 0;
            default: ;
        endcase
    endfunction

    // What the register should look like after the coming edge, given current inputs.
    function automatic void model_edge();
        m_done = 0;
        if (rst) begin
            m_q = 0; m_sr = 0; m_sl = 0; m_rem = 0;
        end else if (m_rem > 0) begin
            model_apply(m_lop, m_lsr, m_lsl, 0);
            m_rem--;
            if (m_rem == 0) m_done = 1;
        end else if (start) begin
            if (is_shift(int'(op))) begin
                if (amt != 0) begin
                    m_rem = int'(amt); m_lop = int'(op); m_lsr = int'(sin_r); m_lsl = int'(sin_l);
                end else begin
                    m_done = 1;
                end
            end else begin
                model_apply(int'(op), 0, 0, int'(pdata));
            end
        end else if (en) begin
            model_apply(int'(op), int'(sin_r), int'(sin_l), int'(pdata));
        end
    endfunction

    // Drive one cycle of inputs, advance the model, and wait until just after the edge.
    task automatic step(input logic r, input logic e, input logic s, input int o,
                        input logic sr, input logic sl, input int pd, input int a);
        rst = r; en = e; start = s; op = 3'(o); sin_r = sr; sin_l = sl;
        pdata = WIDTH'(pd); amt = AMT_W'(a);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1, 8'hFF, 5);
        checks++;
        if ({q, sout_r, sout_l, busy, done} !== 12'h000) begin
            errors++;
            $display("FAIL reset: q=%h sr=%b sl=%b busy=%b done=%b, want all zero", q, sout_r, sout_l, busy, done);
        end
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_single_ops();
        step(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 8'hB4, 0);
        step(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 0, 0);
        checks++;
        if (q !== 8'hDA || sout_r !== 1'b0) begin
            errors++;
            $display("FAIL single_shr: q=%h sout_r=%b, want DA 0", q, sout_r);
        end
        step(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 8'h81, 0);
        step(1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0, 0, 0);
        checks++;
        if (q !== 8'h03 || sout_l !== 1'b1) begin
            errors++;
            $display("FAIL single_rol: q=%h sout_l=%b, want 03 1", q, sout_l);
        end
        step(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 8'h90, 0);
        step(1'b0, 1'b1, 1'b0, 6, 1'b0, 1'b0, 0, 0);
        checks++;
        if (q !== 8'hC8 || sout_r !== 1'b0) begin
            errors++;
            $display("FAIL single_asr: q=%h sout_r=%b, want C8 0", q, sout_r);
        end
        step(1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, 0, 0);
        checks++;
        if (q !== 8'hC8) begin
            errors++;
            $display("FAIL hold_en0: q=%h, want C8", q);
        end
    endtask

    task automatic test_burst_shl();
        logic [7:0] exp_q [3];
        int busy_cycles;
        exp_q[0] = 8'h1E; exp_q[1] = 8'h3C; exp_q[2] = 8'h78;
        busy_cycles = 0;
        step(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 8'h0F, 0);
        step(1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 0, 3);
        checks++;
        if (q !== 8'h0F || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL burst_accept: q=%h busy=%b done=%b, want 0F 1 0", q, busy, done);
        end
        if (busy) busy_cycles++;
        for (int unsigned i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 7, 1'b1, 1'b1, 8'hAA, 9);
            if (busy) busy_cycles++;
            checks++;
            if (q !== exp_q[i] || done !== (i == 2) || busy !== (i != 2)) begin
                errors++;
                $display("FAIL burst_shl[%0d]: q=%h busy=%b done=%b, want %h %b %b",
                         i, q, busy, done, exp_q[i], i != 2, i == 2);
            end
        end
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (done !== 1'b0 || busy_cycles != 3 || sout_l !== 1'b0 || q !== 8'h78) begin
            errors++;
            $display("FAIL burst_end: done=%b busy_cycles=%0d sout_l=%b q=%h, want 0 3 0 78",
                     done, busy_cycles, sout_l, q);
        end
    endtask

    task automatic test_zero_amt();
        step(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 8'h5A, 0);
        step(1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 0, 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h5A) begin
            errors++;
            $display("FAIL zero_amt: done=%b busy=%b q=%h, want 1 0 5A", done, busy, q);
        end
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h5A) begin
            errors++;
            $display("FAIL zero_amt_after: done=%b busy=%b q=%h, want 0 0 5A", done, busy, q);
        end
    endtask

    task automatic test_reset_mid_burst();
        step(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 8'h33, 0);
        step(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 4);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (q !== 8'h99 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_first_shift: q=%h busy=%b, want 99 1", q, busy);
        end
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: q=%h busy=%b done=%b, want 00 0 0", q, busy, done);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
            checks++;
            if (done !== 1'b0 || q !== 8'h00) begin
                errors++;
                $display("FAIL mid_no_done[%0d]: done=%b q=%h, want 0 00", i, done, q);
            end
        end
        step(1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1, 0, 2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart: busy=%b, want 1", busy);
        end
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (q !== 8'h03 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart_end: q=%h done=%b busy=%b, want 03 1 0", q, done, busy);
        end
    endtask

    task automatic test_random();
        int o, a;
        logic r, e, s;
        for (int unsigned i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 59) == 0);
            e = $urandom_range(0, 1);
            s = ($urandom_range(0, 3) == 0);
            o = $urandom_range(0, 7);
            a = $urandom_range(0, 11);
            step(r, e, s, o, 1'($urandom), 1'($urandom), $urandom_range(0, 255), a);
            checks++;
            if (int'(q) != m_q || int'(sout_r) != m_sr || int'(sout_l) != m_sl ||
                int'(busy) != int'(m_rem > 0) || int'(done) != m_done) begin
                errors++;
                $display("FAIL random[%0d]: q=%h sr=%b sl=%b busy=%b done=%b, want %h %0d %0d %0d %0d",
                         i, q, sout_r, sout_l, busy, done, m_q[7:0], m_sr, m_sl, int'(m_rem > 0), m_done);
            end
        end
    endtask

    initial begin
        m_q = 0; m_sr = 0; m_sl = 0; m_done = 0; m_rem = 0; m_lop = 0; m_lsr = 0; m_lsl = 0;
        rst = 1'b1; en = 1'b0; start = 1'b0; op = '0; sin_r = 1'b0; sin_l = 1'b0;
        pdata = '0; amt = '0;
        @(negedge clk);
        test_reset();
        test_single_ops();
        test_burst_shl();
        test_zero_amt();
        test_reset_mid_burst();
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: register width in bits, minimum 2.
REQ-002 The block SHALL have parameter AMT_W, default 4: width of the burst shift-amount port.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit: execute op for one cycle (single-step).
REQ-006 The block SHALL have port op, input, 3 bits, with these encodings:
- 0 = HOLD
- 1 = SHR, logical right shift, sin_r enters the MSB
- 2 = SHL, left shift, sin_l enters the LSB
- 3 = LOAD
- 4 = ROR
- 5 = ROL
- 6 = ASR, arithmetic right shift
- 7 = CLEAR
REQ-007 The block SHALL have port sin_r, input, 1 bit: serial input for SHR.
REQ-008 The block SHALL have port sin_l, input, 1 bit: serial input for SHL.
REQ-009 The block SHALL have port pdata, input, WIDTH bits: parallel load data.
REQ-010 The block SHALL have port amt, input, AMT_W bits: burst shift count.
REQ-011 The block SHALL have port start, input, 1 bit: begin a burst of amt shifts using op.
REQ-012 The block SHALL have port q, output, WIDTH bits: register contents.
REQ-013 The block SHALL have port sout_r, output, 1 bit: registered copy of the last bit that left via the LSB.
REQ-014 The block SHALL have port sout_l, output, 1 bit: registered copy of the last bit that left via the MSB.
REQ-015 The block SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.

Function
REQ-017 In IDLE with start=0 and en=1, the block SHALL apply op exactly once at the next edge.
REQ-018 With start=0 and en=0, q SHALL hold its value.
REQ-019 SHR SHALL set q <= {sin_r, q[W-1:1]} and sout_r <= q[0].
REQ-020 SHL SHALL set q <= {q[W-2:0], sin_l} and sout_l <= q[W-1].
REQ-021 ROR SHALL set q <= {q[0], q[W-1:1]} and sout_r <= q[0].
REQ-022 ROL SHALL set q <= {q[W-2:0], q[W-1]} and sout_l <= q[W-1].
REQ-023 ASR SHALL set q <= {q[W-1], q[W-1:1]} and sout_r <= q[0].
REQ-024 LOAD SHALL set q <= pdata; CLEAR SHALL set q <= 0; HOLD SHALL leave q unchanged.
REQ-025 A sout_* SHALL be updated only by an op that moves a bit out on its side; otherwise it holds.
REQ-026 In IDLE, start SHALL take priority over en.
REQ-027 The state machine SHALL have states IDLE and SHIFT.
REQ-028 Burst acceptance: start=1 in IDLE with op in {SHR, SHL, ROR, ROL, ASR} and amt>0 at edge k SHALL do all of the following:
- latch op, sin_r, sin_l and amt
- set busy=1
- go to SHIFT
- not shift q at edge k
REQ-029 In SHIFT, the block SHALL perform one latched-op shift per edge at edges k+1 through k+amt, decrementing the counter each time.
REQ-030 At edge k+amt (last shift), the block SHALL set busy=0, set done=1 for exactly one cycle, and return to IDLE.
REQ-031 start with amt=0 and a shift op SHALL perform no shift, leave busy low, and pulse done one cycle after the accepting edge.
REQ-032 start with op in {HOLD, LOAD, CLEAR} SHALL execute that op once like en, with no busy and no done.
REQ-033 While busy=1, en, start, op, sin_r, sin_l, pdata and amt SHALL be ignored; the latched values are used.
REQ-034 amt values greater than WIDTH SHALL be honoured literally; e.g. SHR by 10 on WIDTH=8 leaves q filled with the latched sin_r.
REQ-035 A new start in the cycle where done=1 SHALL be accepted normally; burst throughput SHALL be one burst per amt+1 cycles.

Reset
REQ-036 When rst=1 at an edge, the block SHALL set q=0, sout_r=0, sout_l=0, busy=0, done=0, counter=0 and state=IDLE.
REQ-037 rst SHALL override en and start.
REQ-038 rst asserted mid-burst SHALL abort the burst with no done pulse.

Verification (WIDTH=8)
REQ-039 Single SHR: LOAD 8'hB4, then en with op=SHR, sin_r=1 -> q=8'hDA, sout_r=0.
REQ-040 Single ROL: LOAD 8'h81, then en with op=ROL -> q=8'h03, sout_l=1.
REQ-041 Single ASR: LOAD 8'h90, then en with op=ASR -> q=8'hC8, sout_r=0.
REQ-042 Burst SHL: LOAD 8'h0F, then start with op=SHL, amt=3, sin_l=0, plus en pulses during busy -> the following, with en ignored throughout:
- busy high exactly 3 cycles
- q sequence 1E, 3C, 78
- done one cycle
- sout_l=0
REQ-043 Zero-amount burst: start with op=ROR, amt=0, q=8'h5A -> done one cycle after acceptance, busy never high, q=8'h5A.
REQ-044 Reset mid-burst: rst after the first shift of a 4-shift burst -> next edge q=8'h00, busy=0, done stays 0, and a fresh start is accepted immediately.
